// File: rtl/rf_scrubber_pkg.sv
// Shared types and helpers for the register-file background scrubber.
package rf_scrubber_pkg;

    // Default number of cycles between scrub slots
    localparam int SCRUB_PERIOD_DEF = 1024;

    // Register-file address (x0..x31)
    typedef logic [4:0] rf_add;

    // Scrubber FSM states
    typedef enum logic [1:0] {
        SCR_IDLE,
        SCR_REQ,
        SCR_SAMPLE,
        SCR_WAIT
    } scrub_fsm;

    // Walk range: x0 is hard-wired and never scrubbed
    localparam rf_add PTR_FIRST = 5'd1;
    localparam rf_add PTR_LAST  = 5'd31;

    // Next register to scrub, wrapping x31 back to x1
    function automatic rf_add ptr_advance(input rf_add p);
        return (p == PTR_LAST) ? PTR_FIRST : rf_add'(p + 5'd1);
    endfunction

endpackage

// File: rtl/rf_scrubber.sv
// Background register-file scrubber. Borrows the free RF read port 2 once per
// scrub slot, compares both replicas of one register, counts mismatches and
// waits for the correction module to go idle before moving to the next register.
module rf_scrubber
    import rf_scrubber_pkg::*;
#(
    parameter int PERIOD = SCRUB_PERIOD_DEF,
    parameter int CNT_W  = 8
) (
    input  logic             s_clk_i,
    input  logic             s_resetn_i,
    input  logic             s_en_i,
    input  logic             s_clr_i,
    input  logic             s_port_free_i,
    input  logic [31:0]      s_rd_val_i [2],
    input  logic             s_wb_we_i,
    input  rf_add            s_wb_add_i,
    input  logic             s_acm_busy_i,
    output logic             s_rd_req_o,
    output rf_add            s_rd_add_o,
    output logic [CNT_W-1:0] s_err_cnt_o,
    output logic             s_pass_o
);

    localparam int              TMR_W    = $clog2(PERIOD);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PERIOD - 1);

    scrub_fsm         state_reg, state_next;
    logic [TMR_W-1:0] timer_reg, timer_next, timer_inc;
    rf_add            ptr_reg, ptr_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             wait_reg, wait_next;
    logic             pass_reg, pass_next;
    logic             advance;
    logic             cnt_inc;

    assign timer_inc = timer_reg + 1'b1;

    // FSM state register
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            state_reg <= SCR_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Slot timer, scrub pointer, wait flag, mismatch counter and pass pulse
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            timer_reg <= '0;
            ptr_reg   <= PTR_FIRST;
            cnt_reg   <= '0;
            wait_reg  <= 1'b0;
            pass_reg  <= 1'b0;
        end else begin
            timer_reg <= timer_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            wait_reg  <= wait_next;
            pass_reg  <= pass_next;
        end
    end

    // Next-state and datapath update; disable overrides everything but clear
    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        wait_next  = 1'b0;
        pass_next  = 1'b0;
        advance    = 1'b0;
        cnt_inc    = 1'b0;

        case (state_reg)
            SCR_IDLE: begin
                // Slot fires when the incremented count reaches PERIOD-1
                if (timer_inc == TMR_LAST) begin
                    timer_next = '0;
                    state_next = SCR_REQ;
                end else begin
                    timer_next = timer_inc;
                end
            end
            SCR_REQ: begin
                if (s_port_free_i) begin
                    state_next = SCR_SAMPLE;
                end
            end
            SCR_SAMPLE: begin
                // A same-cycle writeback makes the read stale: retry the same register
                if (s_wb_we_i && (s_wb_add_i == ptr_reg)) begin
                    state_next = SCR_REQ;
                end else if (s_rd_val_i[0] != s_rd_val_i[1]) begin
                    cnt_inc    = 1'b1;
                    state_next = SCR_WAIT;
                end else begin
                    advance    = 1'b1;
                    state_next = SCR_IDLE;
                end
            end
            SCR_WAIT: begin
                // First cycle only arms the flag so the correction module gets time to react
                wait_next = 1'b1;
                if (wait_reg && !s_acm_busy_i) begin
                    advance    = 1'b1;
                    state_next = SCR_IDLE;
                end
            end
            default: begin
                state_next = SCR_IDLE;
            end
        endcase

        if (advance) begin
            ptr_next  = ptr_advance(ptr_reg);
            pass_next = (ptr_reg == PTR_LAST);
        end

        if (!s_en_i) begin
            state_next = SCR_IDLE;
            timer_next = '0;
            ptr_next   = ptr_reg;
            wait_next  = 1'b0;
            pass_next  = 1'b0;
            cnt_inc    = 1'b0;
        end

        if (s_clr_i) begin
            cnt_next = '0;
        end else if (cnt_inc && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Outputs: port request only while asking, address always tracks the pointer
    always_comb begin
        s_rd_req_o  = (state_reg == SCR_REQ);
        s_rd_add_o  = ptr_reg;
        s_err_cnt_o = cnt_reg;
        s_pass_o    = pass_reg;
    end

endmodule

// File: tb/tb_rf_scrubber.sv
// Scoreboard bench for rf_scrubber: expected addresses and counter values are
// queued as stimulus is driven and compared when the scrubber responds.
module tb_rf_scrubber;
    import rf_scrubber_pkg::*;

    localparam int PER = 4;
    localparam int CW  = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          clr = 1'b0;
    logic          port_free = 1'b1;
    logic [31:0]   rd_val [2];
    logic          wb_we = 1'b0;
    rf_add         wb_add = '0;
    logic          acm_busy = 1'b0;
    logic          rd_req;
    rf_add         rd_add;
    logic [CW-1:0] err_cnt;
    logic          pass;

    int    n_tests = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    last_req = -1;
    bit    gap_chk = 1'b0;
    int    exp_err = 0;
    rf_add add_q[$];
    int    err_q[$];

    rf_scrubber #(.PERIOD(PER), .CNT_W(CW)) dut (
        .s_clk_i       (clk),
        .s_resetn_i    (rst_n),
        .s_en_i        (en),
        .s_clr_i       (clr),
        .s_port_free_i (port_free),
        .s_rd_val_i    (rd_val),
        .s_wb_we_i     (wb_we),
        .s_wb_add_i    (wb_add),
        .s_acm_busy_i  (acm_busy),
        .s_rd_req_o    (rd_req),
        .s_rd_add_o    (rd_add),
        .s_err_cnt_o   (err_cnt),
        .s_pass_o      (pass)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!rd_req && n < 100) begin
            tick();
            n++;
        end
        check_val("req_seen", rd_req, 1);
    endtask

    // One scrub slot: wait for the request, optionally stall the port, drive the
    // sampled replicas and follow the scrubber through to its next decision.
    task automatic slot(input logic [31:0] v0, input logic [31:0] v1, input int stall,
                        input int busy, input logic we, input rf_add wadd,
                        input logic clr_s, input logic drop);
        rf_add a;
        rf_add nxt;
        logic  hit;
        logic  mism;
        int    n;

        wait_req();
        a = (add_q.size() > 0) ? add_q.pop_front() : rf_add'(0);
        nxt = (a == 5'd31) ? 5'd1 : rf_add'(a + 5'd1);
        check_val("rd_add", rd_add, a);
        if (gap_chk && last_req >= 0) check_val("req_gap", cyc - last_req, 5);
        last_req = cyc;

        if (stall > 0) port_free = 1'b0;
        for (int i = 0; i < stall; i++) begin
            check_val("req_stall", rd_req, 1);
            check_val("add_stall", rd_add, a);
            tick();
        end
        port_free = 1'b1;
        check_val("req_grant", rd_req, 1);
        tick();

        // Sample cycle
        check_val("req_low_sample", rd_req, 0);
        rd_val[0] = v0;
        rd_val[1] = v1;
        wb_we = we;
        wb_add = wadd;
        clr = clr_s;
        if (drop) en = 1'b0;
        hit = we && (wadd == a);
        mism = (v0 != v1);
        if (clr_s) exp_err = 0;
        else if (!drop && !hit && mism) exp_err = (exp_err == CNT_MAX) ? CNT_MAX : exp_err + 1;
        err_q.push_back(exp_err);
        tick();

        wb_we = 1'b0;
        clr = 1'b0;
        rd_val[0] = '0;
        rd_val[1] = '0;
        check_val("err_cnt", err_cnt, err_q.pop_front());

        if (drop) begin
            check_val("drop_req", rd_req, 0);
            check_val("drop_add", rd_add, a);
            add_q.push_back(a);
        end else if (hit) begin
            check_val("retry_req", rd_req, 1);
            check_val("retry_add", rd_add, a);
            check_val("retry_pass", pass, 0);
            add_q.push_back(a);
        end else if (mism) begin
            check_val("wait_min", rd_add, a);
            for (int i = 0; i < busy; i++) begin
                acm_busy = 1'b1;
                check_val("wait_busy", rd_add, a);
                tick();
            end
            acm_busy = 1'b0;
            n = 0;
            while (rd_add == a && n < 4) begin
                tick();
                n++;
            end
            check_val("wait_adv", rd_add, nxt);
            check_val("wait_pass", pass, (a == 5'd31));
            add_q.push_back(nxt);
        end else begin
            check_val("adv_add", rd_add, nxt);
            check_val("adv_pass", pass, (a == 5'd31));
            add_q.push_back(nxt);
        end
    endtask

    initial begin
        logic [31:0] v;
        bit saw_req;

        rd_val[0] = '0;
        rd_val[1] = '0;

        // Reset state
        tick();
        check_val("rst_req", rd_req, 0);
        check_val("rst_add", rd_add, 1);
        check_val("rst_err", err_cnt, 0);
        check_val("rst_pass", pass, 0);
        rst_n = 1'b1;
        en = 1'b1;
        add_q.push_back(5'd1);

        // Full pass x1..x31 then x1 again, equal replicas, fixed slot spacing
        gap_chk = 1'b1;
        for (int i = 0; i < 32; i++) begin
            v = $urandom;
            slot(v, v, 0, 0, 1'b0, 5'd0, 1'b0, 1'b0);
        end
        gap_chk = 1'b0;

        // Walk to x7, then mismatch with correction module busy 3 cycles
        for (int i = 0; i < 5; i++) slot(32'h11, 32'h11, 0, 0, 1'b0, 5'd0, 1'b0, 1'b0);
        slot(32'hA5, 32'hA4, 0, 3, 1'b0, 5'd0, 1'b0, 1'b0);

        // Port busy for 10 cycles at x8
        slot(32'h22, 32'h22, 10, 0, 1'b0, 5'd0, 1'b0, 1'b0);

        // Writeback collision at x12 suppresses the count and retries
        for (int i = 0; i < 3; i++) slot(32'h33, 32'h33, 0, 0, 1'b0, 5'd0, 1'b0, 1'b0);
        slot(32'hDEAD, 32'hBEEF, 0, 0, 1'b1, 5'd12, 1'b0, 1'b0);
        slot(32'h44, 32'h44, 0, 0, 1'b1, 5'd13, 1'b0, 1'b0);

        // Clear, then saturate the 2-bit counter
        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_err = 0;
        check_val("clr_err", err_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            v = $urandom;
            slot(v, ~v, 0, 0, 1'b0, 5'd0, 1'b0, 1'b0);
        end
        // Clear wins over a same-cycle mismatch
        slot(32'h5, 32'h6, 0, 0, 1'b0, 5'd0, 1'b1, 1'b0);

        // Disable during sample: dropped, no request while disabled
        slot(32'h7, 32'h8, 0, 0, 1'b0, 5'd0, 1'b0, 1'b1);
        saw_req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (rd_req) saw_req = 1'b1;
            tick();
        end
        check_val("dis_no_req", saw_req, 0);
        en = 1'b1;
        slot(32'h9, 32'h9, 0, 0, 1'b0, 5'd0, 1'b0, 1'b0);

        // Asynchronous reset while waiting on the correction module
        wait_req();
        check_val("rstw_add", rd_add, (add_q.size() > 0) ? add_q.pop_front() : rf_add'(0));
        tick();
        rd_val[0] = 32'h1;
        rd_val[1] = 32'h2;
        acm_busy = 1'b1;
        tick();
        tick();
        check_val("rstw_err_pre", err_cnt, 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("rstw_req", rd_req, 0);
        check_val("rstw_add0", rd_add, 1);
        check_val("rstw_err", err_cnt, 0);
        check_val("rstw_pass", pass, 0);
        tick();
        rst_n = 1'b1;
        acm_busy = 1'b0;
        rd_val[0] = '0;
        rd_val[1] = '0;
        add_q.delete();
        add_q.push_back(5'd1);
        exp_err = 0;
        slot(32'hC, 32'hC, 0, 0, 1'b0, 5'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
